// File: rtl/booth_secuenciador.sv
// booth_secuenciador: feeds buffered operand pairs to an external Booth
// multiplier (control unit + datapath), waits for Fin with a timeout, and
// hands the signed product to a ready/valid consumer.
module booth_secuenciador #(
    parameter int ANCHO  = 3,
    parameter int PROF   = 2,
    parameter int LIMITE = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ANCHO-1:0]   in_m,
    input  logic [ANCHO-1:0]   in_q,
    output logic               mult_reset,
    output logic [ANCHO-1:0]   mult_m,
    output logic [ANCHO-1:0]   mult_q,
    input  logic               mult_fin,
    input  logic [2*ANCHO-1:0] mult_producto,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*ANCHO-1:0] out_producto,
    output logic               error,
    output logic [7:0]         ops_hechas
);

    localparam int PW = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int CW = $clog2(PROF + 1);
    localparam int TW = (LIMITE > 1) ? $clog2(LIMITE) : 1;

    localparam logic [PW-1:0] PTR_ULT    = PW'(PROF - 1);
    localparam logic [CW-1:0] LLENO      = CW'(PROF);
    localparam logic [TW-1:0] CUENTA_ULT = TW'(LIMITE - 1);

    typedef enum logic [1:0] {
        IDLE,
        LANZA,
        ESPERA,
        ENTREGA
    } estado_t;

    estado_t            estado;
    logic [2*ANCHO-1:0] mem [PROF];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      cuenta;
    logic [TW-1:0]      contador;
    logic               lleno;
    logic               vacio;
    logic               push;
    logic               pop;

    // Buffer status and handshakes; a full buffer never accepts, even while popping
    always_comb begin
        lleno      = (cuenta == LLENO);
        vacio      = (cuenta == '0);
        in_ready   = reset && !lleno;
        push       = in_valid && in_ready;
        pop        = reset && (estado == IDLE) && !vacio;
        mult_reset = !reset || (estado == LANZA);
    end

    // Operand storage, written on every accepted pair
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_m, in_q};
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cuenta <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_ULT) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_ULT) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cuenta <= cuenta + 1'b1;
            end else if (pop && !push) begin
                cuenta <= cuenta - 1'b1;
            end
        end
    end

    // Sequencer: launch, wait for Fin or timeout, deliver the product
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado       <= IDLE;
            out_valid    <= 1'b0;
            out_producto <= '0;
            mult_m       <= '0;
            mult_q       <= '0;
            error        <= 1'b0;
            ops_hechas   <= '0;
            contador     <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (pop) begin
                        {mult_m, mult_q} <= mem[rd_ptr];
                        estado           <= LANZA;
                    end
                end
                LANZA: begin
                    contador <= '0;
                    estado   <= ESPERA;
                end
                ESPERA: begin
                    // Fin takes priority over a timeout on the same cycle
                    if (mult_fin) begin
                        out_producto <= mult_producto;
                        out_valid    <= 1'b1;
                        estado       <= ENTREGA;
                    end else if (contador == CUENTA_ULT) begin
                        error  <= 1'b1;
                        estado <= IDLE;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                ENTREGA: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        ops_hechas <= ops_hechas + 8'd1;
                        estado     <= IDLE;
                    end
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_secuenciador.sv
// Testbench for booth_secuenciador: a 7-state Booth multiplier stand-in drives
// mult_fin/mult_producto, and a queue of expected signed products checks
// every delivered result in order.
module tb_booth_secuenciador;

    localparam int ANCHO  = 3;
    localparam int PROF   = 2;
    localparam int LIMITE = 15;
    localparam int PWID   = 2 * ANCHO;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [ANCHO-1:0] in_m;
    logic [ANCHO-1:0] in_q;
    logic             mult_reset;
    logic [ANCHO-1:0] mult_m;
    logic [ANCHO-1:0] mult_q;
    logic             mult_fin;
    logic [PWID-1:0]  mult_producto;
    logic             out_valid;
    logic             out_ready;
    logic [PWID-1:0]  out_producto;
    logic             error;
    logic [7:0]       ops_hechas;

    int checks = 0;
    int errors = 0;
    int n_deliv = 0;
    logic [PWID-1:0] exp_q[$];

    // Multiplier stand-in: S0 while held in reset, Fin in its seventh state
    logic [2:0] st = '0;
    logic       fin_en = 1'b1;

    booth_secuenciador #(
        .ANCHO (ANCHO),
        .PROF  (PROF),
        .LIMITE(LIMITE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_m         (in_m),
        .in_q         (in_q),
        .mult_reset   (mult_reset),
        .mult_m       (mult_m),
        .mult_q       (mult_q),
        .mult_fin     (mult_fin),
        .mult_producto(mult_producto),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_producto (out_producto),
        .error        (error),
        .ops_hechas   (ops_hechas)
    );

    function automatic int sx(input logic [ANCHO-1:0] v);
        int u;
        u = int'(v);
        return (u >= 2 ** (ANCHO - 1)) ? u - 2 ** ANCHO : u;
    endfunction

    function automatic logic [PWID-1:0] prod(input logic [ANCHO-1:0] m, input logic [ANCHO-1:0] q);
        logic [31:0] t;
        t = 32'(sx(m) * sx(q));
        return t[PWID-1:0];
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mult_reset) st <= 3'd0;
        else if (st < 3'd6) st <= st + 3'd1;
    end

    assign mult_fin      = fin_en && (st == 3'd6);
    assign mult_producto = (st == 3'd6) ? prod(mult_m, mult_q) : ~prod(mult_m, mult_q);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds an operand pair on the input until it is accepted (bounded)
    task automatic offer(input logic [ANCHO-1:0] m, input logic [ANCHO-1:0] q);
        logic got;
        got      = 1'b0;
        in_m     = m;
        in_q     = q;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            got = in_ready;
            step();
            if (got) break;
        end
        in_valid = 1'b0;
        chk("accept", got, 1);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 60; i++) begin
            if (out_valid) break;
            step();
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: record accepted pairs, compare delivered products in order
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (out_valid && out_ready) begin
                chk("out_has_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("out_producto", out_producto, exp_q.pop_front());
                    chk("ops_hechas_pre", ops_hechas, n_deliv % 256);
                    n_deliv++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(prod(in_m, in_q));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PWID-1:0] held;
        logic            seen;

        reset     = 1'b0;
        in_valid  = 1'b1;
        in_m      = 3'd5;
        in_q      = 3'd6;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mult_reset", mult_reset, 1);
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_producto", out_producto, 0);
        chk("rst_mult_m", mult_m, 0);
        chk("rst_mult_q", mult_q, 0);
        chk("rst_error", error, 0);
        chk("rst_ops", ops_hechas, 0);
        chk("rst_in_ready_held", in_ready, 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_mult_reset", mult_reset, 0);
        step();

        // Single operation with exact latency: 3 * 2
        offer(3'd3, 3'd2);
        step();
        chk("lat_mult_m", mult_m, 3);
        chk("lat_mult_q", mult_q, 2);
        chk("lat_lanza_reset", mult_reset, 1);
        step();
        chk("lat_espera_reset", mult_reset, 0);
        repeat (6) step();
        chk("lat_e8_out_valid", out_valid, 0);
        step();
        chk("lat_e9_out_valid", out_valid, 1);
        chk("lat_e9_producto", out_producto, 6'b000110);
        step();
        chk("lat_ops", ops_hechas, 1);
        chk("lat_out_valid_low", out_valid, 0);

        // Signed operation: -4 * 3
        offer(3'b100, 3'b011);
        wait_out();
        chk("signed_producto", out_producto, 6'b110100);
        step();

        // Backpressure: one in flight, two buffered, then the input stalls
        out_ready = 1'b0;
        offer(3'($urandom), 3'($urandom));
        offer(3'($urandom), 3'($urandom));
        offer(3'($urandom), 3'($urandom));
        chk("bp_in_ready_full", in_ready, 0);
        wait_out();
        held = out_producto;
        chk("bp_head", out_producto, exp_q[0]);
        repeat (5) step();
        chk("bp_stable", out_producto, held);
        chk("bp_still_valid", out_valid, 1);
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 150; i++) begin
            in_valid  = 1'($urandom);
            in_m      = 3'($urandom);
            in_q      = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rand_error_clear", error, 0);

        // Timeout: Fin never arrives, LIMITE cycles in ESPERA
        fin_en = 1'b0;
        offer(3'd2, 3'd3);
        step();
        step();
        repeat (LIMITE - 1) step();
        chk("to_before", error, 0);
        step();
        chk("to_error", error, 1);
        chk("to_no_valid", out_valid, 0);
        chk("to_in_ready", in_ready, 1);
        void'(exp_q.pop_front());
        fin_en = 1'b1;
        offer(3'd7, 3'd5);
        drain();
        chk("to_error_sticky", error, 1);

        // Reset in the middle of ESPERA
        offer(3'd3, 3'd3);
        step();
        step();
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("mid_mult_reset", mult_reset, 1);
        chk("mid_in_ready", in_ready, 0);
        step();
        exp_q.delete();
        n_deliv = 0;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_ops", ops_hechas, 0);
        chk("mid_error", error, 0);
        chk("mid_mult_m", mult_m, 0);
        reset = 1'b1;
        #1;
        chk("mid_in_ready_rel", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen = seen | out_valid;
        end
        chk("mid_never_delivered", seen, 0);

        // Wrap of the delivered-operation counter
        for (int i = 0; i < 256; i++) begin
            offer(3'($urandom), 3'($urandom));
        end
        drain();
        chk("wrap_count", n_deliv, 256);
        chk("wrap_ops", ops_hechas, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_secuenciador.md
BOOTH_SECUENCIADOR -- requirements
Module: booth_secuenciador

Interface
REQ-001 Parameter ANCHO, default 3: operand width in bits; the product is 2*ANCHO bits.
REQ-002 Parameter PROF, default 2: input buffer depth in entries.
REQ-003 Parameter LIMITE, default 15: maximum cycles spent in ESPERA before timeout.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low; sampled only on the rising edge of clk.
REQ-006 in_valid  in  1  an operand pair is offered.
REQ-007 in_ready  out  1  the block can accept an operand pair.
REQ-008 in_m  in  ANCHO  multiplicand, two's complement.
REQ-009 in_q  in  ANCHO  multiplier, two's complement.
REQ-010 mult_reset  out  1  active-high reset to the Booth control unit and datapath.
REQ-011 mult_m  out  ANCHO  multiplicand presented to the Booth datapath.
REQ-012 mult_q  out  ANCHO  multiplier presented to the Booth datapath.
REQ-013 mult_fin  in  1  Fin from the Booth control unit.
REQ-014 mult_producto  in  2*ANCHO  A:Q product from the Booth datapath.
REQ-015 out_valid  out  1  a product is held on out_producto.
REQ-016 out_ready  in  1  the consumer accepts the product.
REQ-017 out_producto  out  2*ANCHO  signed product.
REQ-018 error  out  1  sticky timeout flag.
REQ-019 ops_hechas  out  8  count of delivered products.

Function
REQ-020 Input buffer: FIFO of PROF entries {in_m,in_q}; write on in_valid&&in_ready; in_ready = reset && !full; no bypass, so a full buffer never accepts, even in a pop cycle.
REQ-021 FSM states: IDLE, LANZA, ESPERA, ENTREGA.
REQ-022 IDLE with buffer non-empty: pop the head into mult_m/mult_q on that edge and go to LANZA; IDLE with buffer empty: stay in IDLE.
REQ-023 LANZA: exactly one cycle; mult_reset=1; mult_m/mult_q stable; next state ESPERA.
REQ-024 mult_reset = !reset || state==LANZA, combinational, so the multiplier is held in S0 throughout block reset.
REQ-025 ESPERA: count cycles from 0; mult_fin=1 -> capture mult_producto into out_producto, go to ENTREGA.
REQ-026 ESPERA with count reaching LIMITE without mult_fin: set error, discard the operation, return to IDLE.
REQ-027 mult_fin and the timeout in the same cycle: mult_fin wins and error is not set.
REQ-028 ENTREGA: out_valid=1, out_producto held stable until out_valid&&out_ready.
REQ-029 On the ENTREGA handshake edge: increment ops_hechas, go to IDLE.
REQ-030 ops_hechas wraps from 255 to 0.
REQ-031 mult_m/mult_q hold their value until the next pop.
REQ-032 Latency, empty buffer, IDLE, 7-state multiplier: input handshake at edge E0 -> pop at E1 -> LANZA -> ESPERA at E2 -> mult_fin high after E8 -> out_valid high after E9.
REQ-033 Back-to-back: a buffered operand is popped in the first IDLE cycle after ENTREGA completes.
REQ-034 Input accepts continue in every non-IDLE state while the buffer is not full.
REQ-035 mult_fin outside ESPERA is ignored.
REQ-036 error stays set until reset; operation continues normally after error is set.

Reset
REQ-037 reset=0 at a rising edge: state=IDLE, buffer empty, out_valid=0, out_producto=0, mult_m=0, mult_q=0, error=0, ops_hechas=0.
REQ-038 While reset=0: in_ready=0 and mult_reset=1.
REQ-039 reset=0 mid-operation (LANZA, ESPERA or ENTREGA) aborts the operation; its product is never delivered and ops_hechas is not incremented.

Verification
REQ-040 Single op: in_m=3, in_q=2 at E0, out_ready=1 -> out_producto=6 (000110), out_valid after E9, ops_hechas=1.
REQ-041 Signed op: in_m=-4 (100), in_q=3 (011) -> out_producto=-12 (110100).
REQ-042 Backpressure: 3 pairs offered back-to-back with out_ready=0 -> in_ready drops after 2 buffered entries; out_producto stable; products delivered in order once out_ready=1.
REQ-043 Timeout: mult_fin tied 0 -> error=1 after LIMITE cycles in ESPERA; FSM back in IDLE; no out_valid.
REQ-044 Reset mid-ESPERA: reset=0 one edge -> out_valid=0, in_ready=1 after reset releases, ops_hechas=0, mult_reset=1 during reset.
REQ-045 Wrap: 256 handshaked ops -> ops_hechas returns to 0.
